// File: rtl/if_id_branch_unit_if.sv
// Fetch <-> decode link: fetch stage drives the PC/instruction pair, decode
// drives back stall and redirect controls.
// Signals: PC (fetch address + 1, word index), Instruction (fetched word),
// freeze (hold fetch PC and IF/ID), Branch_taken (redirect fetch),
// BranchAddr (redirect target, word index).
interface if_id_branch_unit_if;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] BranchAddr;

  // Fetch stage side
  modport master (
    output PC,
    output Instruction,
    input  freeze,
    input  Branch_taken,
    input  BranchAddr
  );

  // Decode stage side
  modport slave (
    input  PC,
    input  Instruction,
    output freeze,
    output Branch_taken,
    output BranchAddr
  );
endinterface

// File: rtl/if_id_branch_unit.sv
// IF/ID pipeline register with early resolution of B instructions in ID.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   fetch (slave)     PC/Instruction in; freeze/Branch_taken/BranchAddr out
//   hazard            data hazard on the instruction in ID
//   SR                committed flags {N,Z,C,V}
//   flags_busy        a flag-setting instruction in EXE/MEM has not written SR
//   ID_PC             registered PC
//   ID_Instruction    registered instruction
//   ID_valid          ID slot holds a real instruction (not a bubble)
//   taken_count       taken branches since reset, wraps
module if_id_branch_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  if_id_branch_unit_if.slave    fetch,
  input  logic                  hazard,
  input  logic [3:0]            SR,
  input  logic                  flags_busy,
  output logic [31:0]           ID_PC,
  output logic [31:0]           ID_Instruction,
  output logic                  ID_valid,
  output logic [CNT_W-1:0]      taken_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 24;
  localparam logic [2:0]  OP_B    = 3'b101;
  localparam logic [3:0]  COND_AL = 4'b1110;

  logic [XLEN-1:0]  id_pc_q, id_pc_d;
  logic [XLEN-1:0]  id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       cond;
  logic             is_b;
  logic [XLEN-1:0]  br_off;
  logic [XLEN-1:0]  br_addr;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             cond_pass;
  logic             flag_wait;
  logic             freeze_c;
  logic             taken_c;

  // Decode the ID slot; target is computed regardless of instruction type.
  always_comb begin : decode
    cond    = id_instr_q[31:28];
    is_b    = id_valid_q && (id_instr_q[27:25] == OP_B);
    br_off  = {{(XLEN-IMM_W){id_instr_q[IMM_W-1]}}, id_instr_q[IMM_W-1:0]};
    br_addr = id_pc_q + br_off;
  end

  // Condition evaluation against the committed flags.
  always_comb begin : cond_eval
    {flag_n, flag_z, flag_c, flag_v} = SR;
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Stall/redirect: AL never waits for flags; a stall always beats a redirect.
  always_comb begin : resolve
    flag_wait = is_b && (cond != COND_AL) && flags_busy;
    freeze_c  = hazard || flag_wait;
    taken_c   = is_b && cond_pass && !freeze_c;
  end

  // IF/ID next state: hold on freeze, bubble on taken branch, else advance.
  always_comb begin : next_state
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    if (!freeze_c) begin
      if (taken_c) begin
        id_pc_d    = '0;
        id_instr_d = '0;
        id_valid_d = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
      end else begin
        id_pc_d    = fetch.PC;
        id_instr_d = fetch.Instruction;
        id_valid_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fetch.freeze       = freeze_c;
  assign fetch.Branch_taken = taken_c;
  assign fetch.BranchAddr   = br_addr;

  assign ID_PC          = id_pc_q;
  assign ID_Instruction = id_instr_q;
  assign ID_valid       = id_valid_q;
  assign taken_count    = cnt_q;

endmodule

// File: tb/tb_if_id_branch_unit.sv
// Testbench for if_id_branch_unit: directed scenarios plus a randomized
// stream checked against a behavioural model of the IF/ID stage.
module tb_if_id_branch_unit;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] BAL = 32'hEAFF_FFF7;
  localparam logic [31:0] BLT = 32'hBAFF_FFF7;
  localparam logic [31:0] BNV = 32'hFAFF_FFF7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hazard;
  logic [3:0]       SR;
  logic             flags_busy;
  logic [31:0]      ID_PC;
  logic [31:0]      ID_Instruction;
  logic             ID_valid;
  logic [CNT_W-1:0] taken_count;

  if_id_branch_unit_if fif();

  if_id_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch          (fif.slave),
    .hazard         (hazard),
    .SR             (SR),
    .flags_busy     (flags_busy),
    .ID_PC          (ID_PC),
    .ID_Instruction (ID_Instruction),
    .ID_valid       (ID_valid),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the ID slot
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_cnt;

  // Condition codes evaluated in pairs: even code = predicate, odd = inverse.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] sr);
    bit n, z, cf, v, base;
    n = sr[3]; z = sr[2]; cf = sr[1]; v = sr[0];
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    case (int'(c) / 2)
      0: base = z;
      1: base = cf;
      2: base = n;
      3: base = v;
      4: base = cf && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (int'(c) % 2 == 1) ? !base : base;
  endfunction

  function automatic bit ref_is_b();
    return m_valid && (m_instr[27:25] == 3'b101);
  endfunction

  function automatic bit ref_freeze();
    return hazard || (ref_is_b() && (m_instr[31:28] != 4'd14) && flags_busy);
  endfunction

  function automatic bit ref_taken();
    return ref_is_b() && ref_cond(m_instr[31:28], SR) && !ref_freeze();
  endfunction

  function automatic logic [31:0] ref_addr();
    int off;
    off = int'(m_instr[23:0]);
    if (off >= (1 << 23)) off = off - (1 << 24);
    return m_pc + 32'(off);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_instr = '0; m_cnt = 0;
  endtask

  // Advance the model with the inputs present at the clock edge.
  task automatic model_edge();
    if (!rst) model_reset();
    else if (ref_freeze()) begin
    end else if (ref_taken()) begin
      m_valid = 1'b0; m_pc = '0; m_instr = '0;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else begin
      m_valid = 1'b1; m_pc = fif.PC; m_instr = fif.Instruction;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    fif.PC = pc;
    fif.Instruction = ins;
  endtask

  task automatic test_reset();
    hazard = 1'b1; SR = '0; flags_busy = 1'b0; drive(32'd0, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ID_valid); end
    n_cmp++; if (ID_PC !== 32'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", ID_PC); end
    n_cmp++; if (taken_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", taken_count); end
    n_cmp++; if (fif.freeze !== 1'b1) begin n_bad++; $display("FAIL rst_freeze_hz: got %b want 1", fif.freeze); end
    n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL rst_taken: got %b want 0", fif.Branch_taken); end
    n_cmp++; if (fif.BranchAddr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", fif.BranchAddr); end
    hazard = 1'b0;
    #1;
    n_cmp++; if (fif.freeze !== 1'b0) begin n_bad++; $display("FAIL rst_freeze_nohz: got %b want 0", fif.freeze); end
    @(negedge clk); rst = 1'b1;
    drive(32'd5, 32'h1111_0005); step();
    drive(32'd37, BAL); step();
    drive(32'd38, 32'h2222_0026); step();
    drive(32'd50, BAL); step();
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL pre_rst_taken: got %b want 1", fif.Branch_taken); end
    n_cmp++; if (taken_count !== CNT_W'(1)) begin n_bad++; $display("FAIL pre_rst_count: got %0d want 1", taken_count); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (ID_PC !== 32'd0) begin n_bad++; $display("FAIL midrst_pc: got %h want 0", ID_PC); end
    n_cmp++; if (ID_Instruction !== 32'd0) begin n_bad++; $display("FAIL midrst_instr: got %h want 0", ID_Instruction); end
    n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", ID_valid); end
    n_cmp++; if (taken_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", taken_count); end
    n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL midrst_taken: got %b want 0", fif.Branch_taken); end
    step();
    n_cmp++; if (taken_count !== '0) begin n_bad++; $display("FAIL rst_hold_count: got %0d want 0", taken_count); end
    rst = 1'b1;
  endtask

  task automatic test_straight_line();
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] w;
      w = 32'hA5A5_0000 | 32'(i * 32'h111);
      drive(32'(i), w); step();
      #1;
      n_cmp++; if (ID_PC !== 32'(i)) begin n_bad++; $display("FAIL sl_pc%0d: got %h want %h", i, ID_PC, 32'(i)); end
      n_cmp++; if (ID_Instruction !== w) begin n_bad++; $display("FAIL sl_instr%0d: got %h want %h", i, ID_Instruction, w); end
      n_cmp++; if (ID_valid !== 1'b1) begin n_bad++; $display("FAIL sl_valid%0d: got %b want 1", i, ID_valid); end
      n_cmp++; if (fif.freeze !== 1'b0) begin n_bad++; $display("FAIL sl_freeze%0d: got %b want 0", i, fif.freeze); end
    end
  endtask

  task automatic test_bal();
    int c0;
    c0 = m_cnt;
    drive(32'd37, BAL); step();
    drive(32'd38, 32'hDEAD_0026); #1;
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL bal_taken: got %b want 1", fif.Branch_taken); end
    n_cmp++; if (fif.BranchAddr !== 32'd28) begin n_bad++; $display("FAIL bal_addr: got %0d want 28", fif.BranchAddr); end
    step(); #1;
    n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL bal_bubble_valid: got %b want 0", ID_valid); end
    n_cmp++; if (ID_Instruction !== 32'd0) begin n_bad++; $display("FAIL bal_bubble_instr: got %h want 0", ID_Instruction); end
    n_cmp++; if (taken_count !== CNT_W'(c0 + 1)) begin n_bad++; $display("FAIL bal_count: got %0d want %0d", taken_count, c0 + 1); end
    n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL bal_bubble_taken: got %b want 0", fif.Branch_taken); end
  endtask

  task automatic test_blt();
    int c0;
    SR = 4'b1000;
    drive(32'd37, BLT); step(); #1;
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL blt_lt_taken: got %b want 1", fif.Branch_taken); end
    n_cmp++; if (fif.BranchAddr !== 32'd28) begin n_bad++; $display("FAIL blt_lt_addr: got %0d want 28", fif.BranchAddr); end
    drive(32'd38, 32'h5555_0026); step();
    c0 = m_cnt;
    SR = 4'b1001;
    drive(32'd37, BLT); step(); #1;
    n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL blt_ge_taken: got %b want 0", fif.Branch_taken); end
    drive(32'd38, 32'h1234_5678); step(); #1;
    n_cmp++; if (ID_PC !== 32'd38) begin n_bad++; $display("FAIL blt_nt_pc: got %0d want 38", ID_PC); end
    n_cmp++; if (ID_Instruction !== 32'h1234_5678) begin n_bad++; $display("FAIL blt_nt_instr: got %h want 12345678", ID_Instruction); end
    n_cmp++; if (ID_valid !== 1'b1) begin n_bad++; $display("FAIL blt_nt_valid: got %b want 1", ID_valid); end
    n_cmp++; if (taken_count !== CNT_W'(c0)) begin n_bad++; $display("FAIL blt_nt_count: got %0d want %0d", taken_count, c0); end
    drive(32'd37, BNV); step();
    for (int s = 0; s < 16; s++) begin
      SR = 4'(s); #1;
      n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL bnv_taken_sr%0d: got %b want 0", s, fif.Branch_taken); end
      n_cmp++; if (fif.BranchAddr !== 32'd28) begin n_bad++; $display("FAIL bnv_addr_sr%0d: got %0d want 28", s, fif.BranchAddr); end
    end
    drive(32'd38, 32'd0); step();
  endtask

  task automatic test_flag_wait();
    int c0;
    SR = 4'b1000; flags_busy = 1'b0;
    drive(32'd37, BLT); step();
    c0 = m_cnt;
    flags_busy = 1'b1; drive(32'd38, 32'h3333_0026);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (fif.freeze !== 1'b1) begin n_bad++; $display("FAIL fw_freeze%0d: got %b want 1", k, fif.freeze); end
      n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL fw_taken%0d: got %b want 0", k, fif.Branch_taken); end
      n_cmp++; if (ID_PC !== 32'd37) begin n_bad++; $display("FAIL fw_hold%0d: got %0d want 37", k, ID_PC); end
      step();
    end
    flags_busy = 1'b0; #1;
    n_cmp++; if (fif.freeze !== 1'b0) begin n_bad++; $display("FAIL fw_release_freeze: got %b want 0", fif.freeze); end
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL fw_release_taken: got %b want 1", fif.Branch_taken); end
    n_cmp++; if (fif.BranchAddr !== 32'd28) begin n_bad++; $display("FAIL fw_release_addr: got %0d want 28", fif.BranchAddr); end
    step(); #1;
    n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL fw_bubble: got %b want 0", ID_valid); end
    n_cmp++; if (taken_count !== CNT_W'(c0 + 1)) begin n_bad++; $display("FAIL fw_count: got %0d want %0d", taken_count, c0 + 1); end
    flags_busy = 1'b1;
    drive(32'd60, BAL); step(); #1;
    n_cmp++; if (fif.freeze !== 1'b0) begin n_bad++; $display("FAIL fw_al_freeze: got %b want 0", fif.freeze); end
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL fw_al_taken: got %b want 1", fif.Branch_taken); end
    n_cmp++; if (fif.BranchAddr !== 32'd51) begin n_bad++; $display("FAIL fw_al_addr: got %0d want 51", fif.BranchAddr); end
    drive(32'd61, 32'h4444_0000); step();
    flags_busy = 1'b0;
  endtask

  task automatic test_hazard();
    int c0;
    SR = 4'b0000;
    drive(32'd37, BAL); step();
    c0 = m_cnt;
    hazard = 1'b1; drive(32'd38, 32'h6666_0026); #1;
    n_cmp++; if (fif.freeze !== 1'b1) begin n_bad++; $display("FAIL hz_freeze: got %b want 1", fif.freeze); end
    n_cmp++; if (fif.Branch_taken !== 1'b0) begin n_bad++; $display("FAIL hz_taken: got %b want 0", fif.Branch_taken); end
    step(); #1;
    n_cmp++; if (ID_PC !== 32'd37) begin n_bad++; $display("FAIL hz_hold_pc: got %0d want 37", ID_PC); end
    n_cmp++; if (taken_count !== CNT_W'(c0)) begin n_bad++; $display("FAIL hz_count_hold: got %0d want %0d", taken_count, c0); end
    hazard = 1'b0; #1;
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL hz_release_taken: got %b want 1", fif.Branch_taken); end
    step(); #1;
    n_cmp++; if (taken_count !== CNT_W'(c0 + 1)) begin n_bad++; $display("FAIL hz_count: got %0d want %0d", taken_count, c0 + 1); end
    n_cmp++; if (ID_valid !== 1'b0) begin n_bad++; $display("FAIL hz_bubble: got %b want 0", ID_valid); end
    drive(32'hFFFF_FFFF, 32'hEA00_0002); step(); #1;
    n_cmp++; if (fif.BranchAddr !== 32'd1) begin n_bad++; $display("FAIL wrap_addr: got %h want 1", fif.BranchAddr); end
    n_cmp++; if (fif.Branch_taken !== 1'b1) begin n_bad++; $display("FAIL wrap_taken: got %b want 1", fif.Branch_taken); end
    drive(32'd0, 32'd0); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      if ($urandom_range(0, 1) == 1)
        ins = {4'($urandom_range(0, 15)), 3'b101, 1'($urandom), 24'($urandom)};
      else
        ins = $urandom;
      drive($urandom, ins);
      hazard     = ($urandom_range(0, 5) == 0);
      flags_busy = ($urandom_range(0, 3) == 0);
      SR         = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      #1;
      n_cmp++; if (ID_PC !== m_pc) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h want %h", i, ID_PC, m_pc); end
      n_cmp++; if (ID_Instruction !== m_instr) begin n_bad++; $display("FAIL rnd_instr@%0d: got %h want %h", i, ID_Instruction, m_instr); end
      n_cmp++; if (ID_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, ID_valid, m_valid); end
      n_cmp++; if (taken_count !== CNT_W'(m_cnt)) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, taken_count, m_cnt); end
      n_cmp++; if (fif.freeze !== ref_freeze()) begin n_bad++; $display("FAIL rnd_freeze@%0d: got %b want %b", i, fif.freeze, ref_freeze()); end
      n_cmp++; if (fif.Branch_taken !== ref_taken()) begin n_bad++; $display("FAIL rnd_taken@%0d: got %b want %b", i, fif.Branch_taken, ref_taken()); end
      n_cmp++; if (fif.BranchAddr !== ref_addr()) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h want %h", i, fif.BranchAddr, ref_addr()); end
      step();
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_bal();
    test_blt();
    test_flag_wait();
    test_hazard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_branch_unit.md
# if_id_branch_unit

Consumer end of the instruction-fetch interface: registers the fetched `PC`/`Instruction` pair into the decode stage (IF/ID register) and resolves B instructions early in ID. It drives `freeze`, `Branch_taken` and `BranchAddr` back to the fetch stage. It holds the pipeline on external hazards and on conditional branches whose flags are still in flight, and flushes the wrong-path fetch on a taken branch. PCs are word indices throughout.

## Interface
Parameters:
- `CNT_W`, 16, width of taken-branch counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `PC`  in  32  fetch address + 1, from fetch stage
- `Instruction`  in  32  fetched word
- `hazard`  in  1  data hazard on the instruction in ID, from hazard unit
- `SR`  in  4  committed flags {N,Z,C,V}
- `flags_busy`  in  1  an S=1 instruction in EXE/MEM has not yet written `SR`
- `freeze`  out  1  hold fetch PC and IF/ID register
- `Branch_taken`  out  1  redirect fetch to `BranchAddr`
- `BranchAddr`  out  32  branch target (word index)
- `ID_PC`  out  32  registered `PC`
- `ID_Instruction`  out  32  registered instruction
- `ID_valid`  out  1  ID slot holds a real instruction
- `taken_count`  out  `CNT_W`  number of taken branches since reset

## Operation
- Branch decode: `is_b = ID_valid & (ID_Instruction[27:25]==3'b101)`. The cond field is `ID_Instruction[31:28]`.
- Condition pass uses `SR`:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 never
- Target: `BranchAddr = ID_PC + sext(ID_Instruction[23:0])`, 32-bit wrap-around add. It is driven continuously, whatever the value of `is_b`. Bit 24 (link) is ignored.
- `flag_wait = is_b & (cond != 1110) & flags_busy`.
- `freeze = hazard | flag_wait` (combinational).
- `Branch_taken = is_b & cond_pass & ~freeze` (combinational). Freeze always wins over taking the branch.
- IF/ID register update, priority order:
  1. `rst`=0: `ID_PC`, `ID_Instruction`, `ID_valid` and `taken_count` go to 0 asynchronously.
  2. `freeze`: hold all.
  3. `Branch_taken`: load a bubble (`ID_valid`=0, `ID_PC`=0, `ID_Instruction`=0). This discards the wrong-path word currently in fetch.
  4. Otherwise: load `PC`, `Instruction`, set `ID_valid`=1.
- A bubble word of 0 decodes as a real instruction (ANDEQ). Downstream logic must qualify on `ID_valid`. A bubble never triggers a branch.
- `taken_count` increments on each clock edge where `Branch_taken`=1. It wraps at 2^`CNT_W`.
- A not-taken branch advances like any other instruction.

## Timing
- Reset values:
  - `ID_*`=0, `taken_count`=0.
  - `freeze`=`hazard`.
  - `Branch_taken`=0 and `BranchAddr`=0, since the ID slot is empty.
- IF→ID latency is 1 cycle. The branch resolves in the same cycle it sits in ID.
- Fetch redirect happens on the edge after the cycle where `Branch_taken`=1. That edge also loads the bubble, so a taken branch costs exactly 1 bubble.
- `flag_wait` persists until `flags_busy` falls. The branch then resolves in that cycle with the current `SR`. Zero extra bubbles apart from the stall cycles.
- `hazard` and branch asserted together: freeze, no redirect, no count. Resolution is retried each cycle.
- `rst` asserted mid-stall or mid-branch: all state clears immediately. Pending redirect is dropped.
- No path from `PC`/`Instruction` to any output within the same cycle.

## Test plan
- Reset: run straight-line code, drop `rst` between edges -> all `ID_*` and `taken_count` 0 at once. `Branch_taken`=0.
- Straight-line: `PC`=1,2,3 with distinct words -> `ID_PC`/`ID_Instruction` follow 1 cycle later. `ID_valid`=1, `freeze`=0.
- BAL `0xEAFFFFF7` loaded with `PC`=37 -> in ID: `Branch_taken`=1, `BranchAddr`=28. Next cycle: `ID_valid`=0, `taken_count`=1.
- BLT `0xBAFFFFF7`, `ID_PC`=37:
  - `SR`=1000 -> taken, target 28.
  - `SR`=1001 -> not taken, next instruction loads normally.
  - cond 1111 -> never taken.
- BLT in ID with `flags_busy`=1 for 3 cycles -> `freeze`=1, `Branch_taken`=0, ID held for 3 cycles. It resolves in the cycle `flags_busy` drops. A BAL with `flags_busy`=1 does not freeze.
- `hazard`=1 with a taken BAL in ID -> `freeze`=1, `Branch_taken`=0, count unchanged. When `hazard` drops -> taken. Also check `ID_PC`=0xFFFFFFFF with imm +2 -> `BranchAddr`=1.
